lsu_mem_master: RTL

// - Load/store initiator between core execute stage and one port of the shared data RAM.
// - Per request: builds word-aligned address, byte enables, lane-replicated store data;

---
 rtl/lsu_mem_master.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the core execute stage and one
// port of the shared data RAM. It accepts one request at a time and builds the
// word-aligned address, byte enables and lane-replicated store data. It runs the
// valid/ready handshake with memory, then returns a single response pulse. For
// loads the response carries sign- or zero-extended data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are trapped with rsp_err_o instead of being aligned down.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif

module lsu_mem_master #(
  parameter int ADDR_WIDTH = `RISCV_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_uns_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [1:0]            lane_q, lane_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                  rsp_err_q, rsp_err_d;
  logic                  req_misalign;
`endif

  logic [3:0]  req_be;
  logic [31:0] req_wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Decode the incoming request into byte enables and replicated store data
  always_comb begin
    req_be        = 4'b1111;
    req_wdata_rep = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        req_be        = 4'b0001 << req_addr_i[1:0];
        req_wdata_rep = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        req_be        = 4'b0011 << {req_addr_i[1], 1'b0};
        req_wdata_rep = {2{req_wdata_i[15:0]}};
      end
      default: begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata_i;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Half needs an even address, word (and size 11) needs a word-aligned address
  always_comb begin
    req_misalign = 1'b0;
    if (req_size_i == 2'b01)
      req_misalign = req_addr_i[0];
    else if (req_size_i[1])
      req_misalign = |req_addr_i[1:0];
  end
`endif

  // Select the addressed lane of the returned word and extend it
  always_comb begin
    ld_byte = mem_rdata_i[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  // Next-state and output-register logic of the access FSM
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A stale mem_ready_i here is simply ignored
        if (req_valid_i) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_misalign) begin
            // Trap without touching memory; stay ready for the next request
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
          end else begin
`endif
            state_d     = S_WAIT;
            we_d        = req_we_i;
            size_d      = req_size_i;
            uns_d       = req_uns_i;
            lane_d      = req_addr_i[1:0];
            mem_valid_d = 1'b1;
            mem_we_d    = req_we_i ? req_be : 4'b0000;
            mem_addr_d  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = req_wdata_rep;
`ifdef LSU_MISALIGN_TRAP_EN
          end
`endif
        end
      end
      S_WAIT: begin
        // Drop valid in the ready cycle so memory never sees a re-issue
        if (mem_ready_i) begin
          state_d     = S_IDLE;
          mem_valid_d = 1'b0;
          mem_we_d    = 4'b0000;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : ld_ext;
`ifdef LSU_MISALIGN_TRAP_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset (reset also aborts WAIT)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready_o = (state_q == S_IDLE) && !rst;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule
